data_mem_responder: RTL

//  Data-memory end of the CPU load/store interface. Accepts the CPU's address
//  (ALUResultOut), store data (RD2Out) and MemWriteOut, and returns ReadData.

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: posted store buffer in front of a single-port word RAM,
// with load forwarding and a memory-mapped END register. Optional cycle counter
// at CNT_ADDR is enabled by defining DMEM_CYCLE_COUNTER_EN.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          SB_DEPTH    = 4,
  parameter logic [31:0] END_ADDR    = 32'hFFFF_FFF0,
  parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] RD2In,
  input  logic        MemWriteIn,
  input  logic        MemReadIn,
  output logic [31:0] ReadDataOut,
  output logic        StallOut,
  output logic        SbOverflowOut,
  output logic [31:0] END
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] SB_FULL = CW'(SB_DEPTH);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] sb_idx_q  [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [31:0]   end_q, end_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] idx_s;
  logic          is_end_s, is_cnt_s, full_s, pop_s, push_s, store_ram_s;
  logic          fwd_hit_s;
  logic [31:0]   fwd_data_s, load_val_s, cnt_val_s;
  logic [PW-1:0] pos_s;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cnt_q;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_val_s = cnt_q;
`else
  assign cnt_val_s = 32'h0;
`endif

  // Address decode, buffer control and youngest-entry forwarding search.
  always_comb begin
    idx_s       = ALUResultIn[AW+1:2];
    is_end_s    = (ALUResultIn == END_ADDR);
    is_cnt_s    = (ALUResultIn == CNT_ADDR);
    full_s      = (count_q == SB_FULL);
    pop_s       = !MemReadIn && (count_q != {CW{1'b0}});
    store_ram_s = MemWriteIn && !is_end_s && !is_cnt_s;
    push_s      = store_ram_s && (!full_s || pop_s);

    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0;
    pos_s      = {PW{1'b0}};
    // Walk oldest to youngest so the youngest match is left standing.
    for (int i = 0; i < SB_DEPTH; i++) begin
      pos_s = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_idx_q[pos_s] == idx_s)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = sb_data_q[pos_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end

    if (is_end_s) begin
      load_val_s = end_q;
    end else if (is_cnt_s) begin
      load_val_s = cnt_val_s;
    end else if (fwd_hit_s) begin
      load_val_s = fwd_data_s;
    end else begin
      load_val_s = mem[idx_s];
    end
  end

  // Next-state for pointers, occupancy and registered outputs.
  always_comb begin
    rd_ptr_d    = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d    = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    read_data_d = MemReadIn ? load_val_s : read_data_q;
    end_d       = (MemWriteIn && is_end_s) ? RD2In : end_q;
    overflow_d  = overflow_q | (store_ram_s && full_s && !pop_s);
  end

  // Control state; a reset discards every pending store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      read_data_q <= 32'h0;
      end_q       <= 32'h0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      end_q       <= end_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer entry storage; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_idx_q[wr_ptr_q]  <= idx_s;
      sb_data_q[wr_ptr_q] <= RD2In;
    end
  end

  // Single RAM write port, fed by the buffer drain.
  always_ff @(posedge clk) begin
    if (pop_s) begin
      mem[sb_idx_q[rd_ptr_q]] <= sb_data_q[rd_ptr_q];
    end
  end

  assign ReadDataOut   = read_data_q;
  assign StallOut      = full_s;
  assign SbOverflowOut = overflow_q;
  assign END           = end_q;

endmodule
